// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: instruction-memory port, consumer port, redirect and perf counter.
// The design drives the slave side; the memory model and consumer use the master side.
interface fetch_queue_if #(
  parameter int FETCH_WIDTH = 2
);
  logic                      kill;
  logic [31:0]               redirect_pc;
  logic                      imem_req;
  logic [31:0]               imem_addr;
  logic [32*FETCH_WIDTH-1:0] imem_rdata;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_inst;
  logic [31:0]               out_pc;
  logic [31:0]               stall_cycles;

  modport slave (
    input  kill, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_inst, out_pc, stall_cycles
  );

  modport master (
    output kill, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, stall_cycles
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a circular instruction queue, kill/redirect and block-aligned fetch.
// Optional macro FETCH_PERF_CNT_EN enables the fetch-starvation counter on stall_cycles.
module fetch_queue #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_queue_if.slave  bus
);

  localparam int BLK_BYTES = 4 * FETCH_WIDTH;
  localparam int BLK_BITS  = $clog2(BLK_BYTES);
  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam cnt_t        FW_C     = cnt_t'(FETCH_WIDTH);
  localparam cnt_t        QD_C     = cnt_t'(QUEUE_DEPTH);
  localparam logic [31:0] BLK_MASK = ~(32'(BLK_BYTES) - 32'd1);

  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_inflight;
  cnt_t        r_off;
  ptr_t        r_head;
  ptr_t        r_tail;
  cnt_t        r_count;
  logic [31:0] r_inst [QUEUE_DEPTH];
  logic [31:0] r_qpc  [QUEUE_DEPTH];

  logic [31:0] w_addr;
  cnt_t        w_off;
  cnt_t        w_inflight_lanes;
  cnt_t        w_free;
  logic        w_req;
  logic        w_enq;
  cnt_t        w_enq_lanes;
  logic        w_valid;
  logic        w_deq;

  assign w_addr           = r_pc & BLK_MASK;
  assign w_off            = cnt_t'(r_pc[BLK_BITS-1:0] >> 2);
  // Reserving room for the outstanding lanes up front is what makes overflow impossible.
  assign w_inflight_lanes = r_inflight ? (FW_C - r_off) : '0;
  assign w_free           = QD_C - r_count - w_inflight_lanes;
  assign w_req            = reset_n && !bus.kill && (w_free >= FW_C);
  assign w_enq            = r_inflight && !bus.kill;
  assign w_enq_lanes      = w_enq ? (FW_C - r_off) : '0;
  assign w_valid          = (r_count != '0) && !bus.kill;
  assign w_deq            = w_valid && bus.out_ready;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = w_addr;
  assign bus.out_valid = w_valid;
  assign bus.out_inst  = r_inst[r_head];
  assign bus.out_pc    = r_qpc[r_head];

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_off      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (bus.kill) begin
      r_pc       <= bus.redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc       <= w_addr + 32'(BLK_BYTES);
        r_req_addr <= w_addr;
        r_off      <= w_off;
      end
      r_tail  <= r_tail + w_enq_lanes[PTR_W-1:0];
      r_head  <= r_head + ptr_t'(w_deq);
      r_count <= r_count + w_enq_lanes - cnt_t'(w_deq);
    end
  end

  // NOTE: queue storage has no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int l = 0; l < FETCH_WIDTH; l++) begin
        if (cnt_t'(l) >= r_off) begin
          r_inst[r_tail + ptr_t'(l) - r_off[PTR_W-1:0]] <= bus.imem_rdata[32*l +: 32];
          r_qpc[r_tail + ptr_t'(l) - r_off[PTR_W-1:0]]  <= r_req_addr + 32'(4 * l);
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall;

  // Counts consumer-ready cycles with nothing to hand over; survives kill, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= '0;
    end else if (bus.out_ready && !w_valid && !bus.kill) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (FETCH_WIDTH=2, QUEUE_DEPTH=4, RESET_PC=0).
// Inputs change and outputs are sampled just after the falling edge.
module tb_fetch_queue;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.FETCH_WIDTH(2)) ifc ();

  fetch_queue #(
    .FETCH_WIDTH(2),
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: always ready, one-cycle latency.
  always @(posedge clk) begin
    if (ifc.imem_req) begin
      for (int i = 0; i < 2; i++) ifc.imem_rdata[32*i +: 32] <= mem_word(ifc.imem_addr + 32'(4 * i));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset_n         = 1'b0;
    ifc.kill        = 1'b0;
    ifc.redirect_pc = 32'h0;
    ifc.out_ready   = rdy;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    ifc.kill        = 1'b0;
    ifc.redirect_pc = 32'h0;
    ifc.out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (ifc.imem_req !== 1'b0) $display("FAIL reset_req got %0b exp 0", ifc.imem_req); else n_pass++;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.stall_cycles !== 32'd0) $display("FAIL reset_stall got %0d exp 0", ifc.stall_cycles); else n_pass++;
    reset_n = 1'b1;
    #1;
    n_total++; if (ifc.imem_req !== 1'b1) $display("FAIL release_req got %0b exp 1", ifc.imem_req); else n_pass++;
    n_total++; if (ifc.imem_addr !== 32'h0) $display("FAIL release_addr got %h exp 00000000", ifc.imem_addr); else n_pass++;
  endtask

  task automatic test_stream();
    logic        e_valid, e_req;
    logic [31:0] e_pc, e_addr, e_stall;
    do_reset(1'b1);
    for (int c = 0; c < 12; c++) begin
      e_valid = (c >= 2);
      e_pc    = 32'(4 * (c - 2));
      e_req   = (c < 2) || (c >= 4 && c % 2 == 0);
      e_addr  = (c == 1) ? 32'h8 : 32'(4 * c);
      e_stall = PERF ? ((c < 2) ? 32'(c) : 32'd2) : 32'd0;
      n_total++; if (ifc.out_valid !== e_valid) $display("FAIL stream_valid c%0d got %0b exp %0b", c, ifc.out_valid, e_valid); else n_pass++;
      n_total++; if (ifc.imem_req !== e_req) $display("FAIL stream_req c%0d got %0b exp %0b", c, ifc.imem_req, e_req); else n_pass++;
      n_total++; if (ifc.stall_cycles !== e_stall) $display("FAIL stream_stall c%0d got %0d exp %0d", c, ifc.stall_cycles, e_stall); else n_pass++;
      if (e_req) begin
        n_total++; if (ifc.imem_addr !== e_addr) $display("FAIL stream_addr c%0d got %h exp %h", c, ifc.imem_addr, e_addr); else n_pass++;
      end
      if (e_valid) begin
        n_total++; if (ifc.out_pc !== e_pc) $display("FAIL stream_pc c%0d got %h exp %h", c, ifc.out_pc, e_pc); else n_pass++;
        n_total++; if (ifc.out_inst !== mem_word(e_pc)) $display("FAIL stream_inst c%0d got %h exp %h", c, ifc.out_inst, mem_word(e_pc)); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int ereq  [12] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    int eaddr [12] = '{'h0, 'h8, 0, 0, 0, 0, 0, 'h10, 0, 'h18, 0, 'h20};
    int epc   [12] = '{0, 0, 'h0, 'h0, 'h0, 'h0, 'h4, 'h8, 'hC, 'h10, 'h14, 'h18};
    do_reset(1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c == 5) begin
        ifc.out_ready = 1'b1;
        #1;
      end
      n_total++; if (ifc.imem_req !== ereq[c][0]) $display("FAIL bp_req c%0d got %0b exp %0b", c, ifc.imem_req, ereq[c][0]); else n_pass++;
      if (ereq[c] == 1) begin
        n_total++; if (ifc.imem_addr !== 32'(eaddr[c])) $display("FAIL bp_addr c%0d got %h exp %h", c, ifc.imem_addr, 32'(eaddr[c])); else n_pass++;
      end
      n_total++; if (ifc.out_valid !== (c >= 2)) $display("FAIL bp_valid c%0d got %0b exp %0b", c, ifc.out_valid, (c >= 2)); else n_pass++;
      if (c >= 2) begin
        n_total++; if (ifc.out_pc !== 32'(epc[c])) $display("FAIL bp_pc c%0d got %h exp %h", c, ifc.out_pc, 32'(epc[c])); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_kill_redirect();
    do_reset(1'b1);
    repeat (5) step();
    n_total++; if (ifc.out_pc !== 32'hC) $display("FAIL kr_pre_pc got %h exp 0000000c", ifc.out_pc); else n_pass++;
    ifc.kill        = 1'b1;
    ifc.redirect_pc = 32'h104;
    #1;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL kr_kill_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.imem_req !== 1'b0) $display("FAIL kr_kill_req got %0b exp 0", ifc.imem_req); else n_pass++;
    step();
    ifc.kill = 1'b0;
    #1;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL kr_c6_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.imem_req !== 1'b1) $display("FAIL kr_c6_req got %0b exp 1", ifc.imem_req); else n_pass++;
    n_total++; if (ifc.imem_addr !== 32'h100) $display("FAIL kr_c6_addr got %h exp 00000100", ifc.imem_addr); else n_pass++;
    n_total++; if (ifc.stall_cycles !== (PERF ? 32'd2 : 32'd0)) $display("FAIL kr_c6_stall got %0d exp %0d", ifc.stall_cycles, PERF ? 2 : 0); else n_pass++;
    step();
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL kr_c7_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.imem_addr !== 32'h108) $display("FAIL kr_c7_addr got %h exp 00000108", ifc.imem_addr); else n_pass++;
    step();
    n_total++; if (ifc.out_valid !== 1'b1) $display("FAIL kr_c8_valid got %0b exp 1", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.out_pc !== 32'h104) $display("FAIL kr_c8_pc got %h exp 00000104", ifc.out_pc); else n_pass++;
    n_total++; if (ifc.out_inst !== mem_word(32'h104)) $display("FAIL kr_c8_inst got %h exp %h", ifc.out_inst, mem_word(32'h104)); else n_pass++;
    n_total++; if (ifc.stall_cycles !== (PERF ? 32'd4 : 32'd0)) $display("FAIL kr_c8_stall got %0d exp %0d", ifc.stall_cycles, PERF ? 4 : 0); else n_pass++;
    step();
    n_total++; if (ifc.out_pc !== 32'h108) $display("FAIL kr_c9_pc got %h exp 00000108", ifc.out_pc); else n_pass++;
    step();
    n_total++; if (ifc.out_pc !== 32'h10C) $display("FAIL kr_c10_pc got %h exp 0000010c", ifc.out_pc); else n_pass++;
  endtask

  task automatic test_kill_response();
    do_reset(1'b1);
    repeat (7) step();
    ifc.kill        = 1'b1;
    ifc.redirect_pc = 32'h40;
    #1;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL krsp_kill_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.imem_req !== 1'b0) $display("FAIL krsp_kill_req got %0b exp 0", ifc.imem_req); else n_pass++;
    step();
    ifc.kill = 1'b0;
    #1;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL krsp_next_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.imem_req !== 1'b1) $display("FAIL krsp_next_req got %0b exp 1", ifc.imem_req); else n_pass++;
    n_total++; if (ifc.imem_addr !== 32'h40) $display("FAIL krsp_next_addr got %h exp 00000040", ifc.imem_addr); else n_pass++;
    step();
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL krsp_c9_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.imem_addr !== 32'h48) $display("FAIL krsp_c9_addr got %h exp 00000048", ifc.imem_addr); else n_pass++;
    step();
    n_total++; if (ifc.out_pc !== 32'h40) $display("FAIL krsp_c10_pc got %h exp 00000040", ifc.out_pc); else n_pass++;
  endtask

  task automatic test_back_to_back_kill();
    do_reset(1'b1);
    repeat (5) step();
    ifc.kill        = 1'b1;
    ifc.redirect_pc = 32'h200;
    step();
    ifc.redirect_pc = 32'h300;
    #1;
    n_total++; if (ifc.imem_req !== 1'b0) $display("FAIL b2b_kill2_req got %0b exp 0", ifc.imem_req); else n_pass++;
    step();
    ifc.kill = 1'b0;
    #1;
    n_total++; if (ifc.imem_addr !== 32'h300) $display("FAIL b2b_addr got %h exp 00000300", ifc.imem_addr); else n_pass++;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL b2b_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    step();
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL b2b_rsp_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    step();
    n_total++; if (ifc.out_pc !== 32'h300) $display("FAIL b2b_pc0 got %h exp 00000300", ifc.out_pc); else n_pass++;
    step();
    n_total++; if (ifc.out_pc !== 32'h304) $display("FAIL b2b_pc1 got %h exp 00000304", ifc.out_pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    repeat (3) step();
    n_total++; if (ifc.out_pc !== 32'h4) $display("FAIL rm_pre_pc got %h exp 00000004", ifc.out_pc); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL rm_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.imem_req !== 1'b0) $display("FAIL rm_req got %0b exp 0", ifc.imem_req); else n_pass++;
    n_total++; if (ifc.stall_cycles !== 32'd0) $display("FAIL rm_stall got %0d exp 0", ifc.stall_cycles); else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_total++; if (ifc.imem_req !== 1'b1) $display("FAIL rm_rel_req got %0b exp 1", ifc.imem_req); else n_pass++;
    n_total++; if (ifc.imem_addr !== 32'h0) $display("FAIL rm_rel_addr got %h exp 00000000", ifc.imem_addr); else n_pass++;
    n_total++; if (ifc.out_valid !== 1'b0) $display("FAIL rm_rel_valid got %0b exp 0", ifc.out_valid); else n_pass++;
    step();
    step();
    n_total++; if (ifc.out_valid !== 1'b1) $display("FAIL rm_first_valid got %0b exp 1", ifc.out_valid); else n_pass++;
    n_total++; if (ifc.out_pc !== 32'h0) $display("FAIL rm_first_pc got %h exp 00000000", ifc.out_pc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_kill_redirect();
    test_kill_response();
    test_back_to_back_kill();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter FETCH_WIDTH, default 2: instructions per fetch block (1, 2 or 4); block size is 4*FETCH_WIDTH bytes.
REQ-002 Parameter QUEUE_DEPTH, default 4: instruction queue entries; power of 2, at least 2*FETCH_WIDTH.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch PC after reset.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 kill  in  1  flush queue and redirect fetch.
REQ-007 redirect_pc  in  32  new fetch PC, sampled when kill=1.
REQ-008 imem_req  out  1  fetch request this cycle.
REQ-009 imem_addr  out  32  block-aligned fetch address: pc with bits [log2(4*FETCH_WIDTH)-1:0] cleared.
REQ-010 imem_rdata  in  32*FETCH_WIDTH  block data, one cycle after request; lane i = word at imem_addr+4i.
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  consumer accepts head.
REQ-013 out_inst  out  32  head instruction.
REQ-014 out_pc  out  32  head instruction PC.
REQ-015 stall_cycles  out  32  fetch-starvation counter (see Configuration).

Function
REQ-016 Memory model: synchronous, always ready, fixed 1-cycle latency; at most one block in flight.
REQ-017 imem_req=1 iff reset_n=1, kill=0, and QUEUE_DEPTH - count - inflight_lanes >= FETCH_WIDTH.
REQ-018 On a request, pc <= imem_addr + 4*FETCH_WIDTH; pc is held when no request is issued.
REQ-019 Request offset off = pc[log2(4*FETCH_WIDTH)-1:2], registered with the request; the response enqueues lanes off..FETCH_WIDTH-1 in ascending order, with PC = imem_addr+4*lane.
REQ-020 inflight_lanes = FETCH_WIDTH - off of the outstanding request, or 0 if none; this guarantees no overflow.
REQ-021 Dequeue when out_valid=1 and out_ready=1; one instruction per cycle; strict program order.
REQ-022 Enqueue and dequeue in the same cycle are both performed; count = count + enq_lanes - deq.
REQ-023 out_valid = (count != 0) and kill=0; out_inst/out_pc are the head entry and don't-care when out_valid=0.
REQ-024 First instruction appears at out_valid two cycles after the first request (request cycle, then response-enqueue cycle).
REQ-025 kill=1 cycle:
  - queue cleared (count <= 0), head/tail pointers reset;
  - any pop is ignored;
  - imem_req=0;
  - pc <= redirect_pc;
  - the response arriving in the next cycle is discarded.
REQ-026 Fetch resumes the cycle after kill at redirect_pc's block, using offset semantics for a mid-block target.
REQ-027 Back-to-back kills: the last kill wins; nothing from earlier redirects is enqueued.
REQ-028 Queue pointers wrap modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH.

Reset
REQ-029 reset_n=0 asynchronously sets: pc=RESET_PC, count=0, no request in flight, imem_req=0, out_valid=0, stall_cycles=0.
REQ-030 Assertion mid-operation discards queue contents and the in-flight response; first request is the first cycle after deassertion.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined:
  - stall_cycles increments (wrapping at 2^32) each cycle with out_ready=1, out_valid=0, kill=0, reset_n=1;
  - it is not cleared by kill.
REQ-032 Macro FETCH_PERF_CNT_EN undefined: stall_cycles is tied to 0, no counter logic is synthesized, and the port list is unchanged.

Verification (FETCH_WIDTH=2, QUEUE_DEPTH=4, RESET_PC=0)
REQ-033 Release reset, out_ready=1 -> imem_addr 0x0,0x8,0x10...; out_pc 0x0,0x4,0x8... every cycle once streaming; first out_valid two cycles after release.
REQ-034 out_ready=0 -> count reaches 4, imem_req drops after two blocks, no entry lost; raise out_ready -> PCs 0x0..0xC delivered in order, then fetching resumes at 0x10.
REQ-035 kill with redirect_pc=0x104 while queue is non-empty and a request is in flight -> out_valid=0 next cycle; imem_addr=0x100; only lane 1 enqueued; first out_pc=0x104, then 0x108.
REQ-036 kill coincident with a response and out_ready=1 -> no enqueue, no pop, count=0; next cycle imem_req=1 at redirect block.
REQ-037 Drop reset_n mid-stream with 3 entries queued -> out_valid=0 and imem_req=0 immediately (asynchronous); after release, refetch from 0x0.
REQ-038 FETCH_PERF_CNT_EN defined, out_ready=1 from reset release -> stall_cycles=2 at first out_valid; undefined -> stall_cycles stays 0 throughout.
